// File: rtl/slice_scheduler.sv
// Angular slice scheduler: measures the rotor period between hall syncs and
// splits each revolution into NB_SLICES equal slices, handshaking each to the driver.
module slice_scheduler #(
  parameter int NB_SLICES    = 128,
  parameter int PERIOD_WIDTH = 24,
  parameter int MIN_PERIOD   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_enable,
  input  logic                         position_sync,
  input  logic                         driver_ready,
  output logic                         slice_start,
  output logic [$clog2(NB_SLICES)-1:0] slice_index,
  output logic [PERIOD_WIDTH-1:0]      rotation_period,
  output logic                         period_valid,
  output logic                         overrun,
  output logic                         stalled
);

  localparam int IDX_W = $clog2(NB_SLICES);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, RUN, STALL} state_t;

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic                    start_q, overrun_q;
  logic                    request, drop, issue, sync_ok;

  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
  // Glitch reject: the period including this cycle must reach MIN_PERIOD.
  assign sync_ok = position_sync && (cnt_inc >= PERIOD_WIDTH'(MIN_PERIOD));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    period_d = period_q;
    idx_d    = idx_q;
    request  = 1'b0;
    drop     = 1'b0;
    if (clk_enable) begin
      unique case (state_q)
        IDLE, STALL: begin
          if (position_sync) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        MEASURE, RUN: begin
          cnt_d = cnt_inc;
          if (sync_ok) begin
            // A sync always wins over a coincident slice timer expiry.
            state_d  = RUN;
            period_d = cnt_inc;
            cnt_d    = '0;
            idx_d    = '0;
            timer_d  = cnt_inc >> IDX_W;
            request  = 1'b1;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = STALL;
            drop    = 1'b1;
          end else if (state_q == RUN) begin
            if (timer_q == PERIOD_WIDTH'(1)) begin
              timer_d = period_q >> IDX_W;
              if (idx_q != IDX_W'(NB_SLICES - 1)) begin
                idx_d   = idx_q + 1'b1;
                request = 1'b1;
              end
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The handshake runs on every clk, independent of clk_enable.
  assign issue = pending_q && driver_ready && !drop;

  always_comb begin
    pending_d = pending_q;
    if (drop)         pending_d = 1'b0;
    else if (request) pending_d = 1'b1;
    else if (issue)   pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timer_q   <= '0;
      period_q  <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      start_q   <= issue;
      // A request landing on an unissued one loses a slice boundary.
      overrun_q <= overrun_q | (request && pending_q && !driver_ready);
    end
  end

  assign slice_start     = start_q;
  assign slice_index     = idx_q;
  assign rotation_period = period_q;
  assign period_valid    = (state_q == RUN);
  assign stalled         = (state_q == STALL);
  assign overrun         = overrun_q;

endmodule
